nand3_response_checker: RTL

Synthesizable response checker for the 3-input NAND gate. It sits on the DUT output side and consumes handshaked samples of the applied inputs and the observed output, each as {a, b, c, y}. It compares y against ~(a&b&c), tracks which of the 8 input combinations have been exercised, and counts mismatches. When coverage completes or the stream stalls, it reports a pass/fail verdict.

---
 rtl/nand3_response_checker.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/nand3_response_checker.sv
// nand3_response_checker
//
// Checks the response of a 3-input NAND gate. Each accepted sample carries
// the inputs that were applied to the gate and the output seen from it. The
// checker compares that output with ~(a & b & c), records which of the eight
// input combinations have been seen, and counts mismatches. It reports a
// verdict once every combination has been seen, or once no sample has
// arrived for TIMEOUT cycles.
//
// Parameters
//   CNT_W    width of the mismatch counter, which saturates
//   TIMEOUT  idle COLLECT cycles before the session aborts (0 = never)
//
// Ports
//   clk             clock, rising edge
//   rst             synchronous active-high reset
//   start           one-cycle pulse: begin or restart a session
//   in_valid        sample present on in_a/in_b/in_c/in_y
//   in_ready        checker can accept a sample (state COLLECT)
//   in_a/b/c        gate inputs as applied
//   in_y            gate output as observed
//   busy            session in progress (COLLECT)
//   done            verdict valid (DONE)
//   pass            no mismatches, full coverage, no timeout
//   timeout         session ended because samples stopped arriving
//   err_cnt         saturating mismatch count
//   cov_mask        bit {a,b,c} set once that combination was accepted
//   first_fail      {a,b,c,y} of the first mismatching sample
//   first_fail_vld  first_fail holds a captured sample

module nand3_response_checker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_a,
    input  logic             in_b,
    input  logic             in_c,
    input  logic             in_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] err_cnt,
    output logic [7:0]       cov_mask,
    output logic [3:0]       first_fail,
    output logic             first_fail_vld
);

    localparam int unsigned STALL_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned STALL_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [STALL_W-1:0] stall_cnt;
    logic               accept;
    logic [2:0]         idx;
    logic               mismatch;
    logic [7:0]         cov_nxt;
    logic [CNT_W-1:0]   err_nxt;
    logic               cov_full;
    logic               stall_hit;

    // start takes priority over a sample presented in the same cycle
    assign accept    = (state == COLLECT) && in_valid && !start;
    assign idx       = {in_a, in_b, in_c};
    assign mismatch  = (in_y != ~(in_a & in_b & in_c));
    assign cov_nxt   = cov_mask | (8'd1 << idx);
    assign err_nxt   = (mismatch && (err_cnt != '1)) ? err_cnt + 1'b1 : err_cnt;
    assign cov_full  = accept && (cov_nxt == 8'hFF);
    // The last idle cycle before the abort is the one where the counter
    // already holds TIMEOUT-1 and no sample arrives.
    assign stall_hit = (TIMEOUT != 0) && (state == COLLECT) && !start && !accept
                       && (stall_cnt == STALL_W'(STALL_LAST));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                if (start)          state_nxt = COLLECT;
                else if (cov_full)  state_nxt = DONE;
                else if (stall_hit) state_nxt = DONE;
            end
            DONE: begin
                if (start) state_nxt = COLLECT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            COLLECT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Result registers and stall counter
    always_ff @(posedge clk) begin
        if (rst || start) begin
            // every start enters COLLECT, so clearing here covers all entries
            err_cnt        <= '0;
            cov_mask       <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            stall_cnt      <= '0;
        end else if (state == COLLECT) begin
            if (accept) begin
                stall_cnt <= '0;
                cov_mask  <= cov_nxt;
                err_cnt   <= err_nxt;
                if (mismatch && !first_fail_vld) begin
                    first_fail     <= {in_a, in_b, in_c, in_y};
                    first_fail_vld <= 1'b1;
                end
                // judged on the updated count so a bad final sample fails
                if (cov_nxt == 8'hFF) begin
                    pass <= (err_nxt == '0);
                end
            end else begin
                stall_cnt <= stall_cnt + 1'b1;
                if (stall_hit) begin
                    timeout <= 1'b1;
                    pass    <= 1'b0;
                end
            end
        end
    end

endmodule
